// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker for the lfsr pattern generator.
// Self-synchronises to the serial stream (HUNT -> VERIFY -> LOCKED), then
// runs a free-running reference and counts mismatches in a saturating counter.
// Optional build macro LFSR_CHECKER_INVERT_EN adds an `invert` input that
// flips the polarity of every received bit.
module lfsr_checker #(
    parameter int WIDTH      = 5,
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reinit,
    input  logic [WIDTH-1:0] taps,
    input  logic             in_valid,
    input  logic             in_bit,
`ifdef LFSR_CHECKER_INVERT_EN
    input  logic             invert,
`endif
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] exp_state
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  h, h_nxt;
    logic [FILL_W-1:0] fill_cnt, fill_nxt;
    logic [CNT_W-1:0]  match_cnt, match_nxt;
    logic [CNT_W-1:0]  miss_cnt, miss_nxt;
    logic              pulse_nxt;
    logic              err_inc;

    logic bit_eff;
    logic pred;
    logic match;
    logic h_zero;
    logic fill_done;
    logic lock_hit;
    logic loss_hit;

`ifdef LFSR_CHECKER_INVERT_EN
    assign bit_eff = in_bit ^ invert;
`else
    assign bit_eff = in_bit;
`endif

    assign pred      = ^(taps & h);
    assign match     = (bit_eff == pred);
    assign h_zero    = (h == '0);
    assign fill_done = (fill_cnt == FILL_W'(WIDTH - 1));
    assign lock_hit  = (match_cnt == CNT_W'(LOCK_COUNT - 1));
    assign loss_hit  = (miss_cnt == CNT_W'(LOSS_COUNT - 1));

    assign locked    = (state == LOCKED);
    assign exp_state = h;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_nxt;
    end

    // Next-state logic; reinit dominates any accepted bit
    always_comb begin
        state_nxt = state;
        if (reinit) begin
            state_nxt = HUNT;
        end else if (in_valid) begin
            case (state)
                HUNT:    if (fill_done) state_nxt = VERIFY;
                VERIFY:  if (match && !h_zero && lock_hit) state_nxt = LOCKED;
                LOCKED:  if (!match && loss_hit) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Datapath next values: history shift source, sync counters, error flag
    always_comb begin
        h_nxt     = h;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        pulse_nxt = 1'b0;
        err_inc   = 1'b0;
        if (reinit) begin
            h_nxt     = '0;
            fill_nxt  = '0;
            match_nxt = '0;
            miss_nxt  = '0;
        end else if (in_valid) begin
            case (state)
                HUNT: begin
                    h_nxt     = {h[WIDTH-2:0], bit_eff};
                    fill_nxt  = fill_cnt + FILL_W'(1);
                    match_nxt = '0;
                end
                VERIFY: begin
                    h_nxt    = {h[WIDTH-2:0], bit_eff};
                    miss_nxt = '0;
                    // an all-zero history predicts 0 and would match a dead link
                    if (!match)      match_nxt = '0;
                    else if (!h_zero) match_nxt = match_cnt + CNT_W'(1);
                end
                LOCKED: begin
                    // reference runs on its own prediction so errors do not propagate
                    h_nxt = {h[WIDTH-2:0], pred};
                    if (!match) begin
                        pulse_nxt = 1'b1;
                        err_inc   = 1'b1;
                        miss_nxt  = miss_cnt + CNT_W'(1);
                        if (loss_hit) begin
                            fill_nxt = '0;
                            miss_nxt = '0;
                        end
                    end else begin
                        miss_nxt = '0;
                    end
                end
                default: begin
                    h_nxt = h;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
        end else begin
            h         <= h_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err_pulse <= pulse_nxt;
        end
    end

    // Saturating error counter; a clear colliding with an error leaves 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= err_inc ? ERR_W'(1) : '0;
        end else if (err_inc && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed self-checking bench for lfsr_checker.
// A behavioural generator model supplies the reference stream and state.
module tb_lfsr_checker;

    localparam logic [4:0] TAPS = 5'b10100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reinit = 1'b0;
    logic [4:0]  taps = TAPS;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clr_err = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [4:0]  exp_state;

    int checks = 0;
    int failures = 0;
    logic [4:0] gen;

    lfsr_checker #(.WIDTH(5), .LOCK_COUNT(8), .LOSS_COUNT(4), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .taps(taps),
        .in_valid(in_valid), .in_bit(in_bit), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .exp_state(exp_state)
    );

    always #5 clk = ~clk;

    task automatic gen_next(output logic b);
        b = ^(TAPS & gen);
        gen = {gen[3:0], b};
    endtask

    // drive one cycle of input, then sample just after the edge
    task automatic tick(input logic v, input logic b);
        in_valid = v;
        in_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; reinit = 1'b0; clr_err = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        taps = TAPS;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gen = 5'b00001;
    endtask

    task automatic send_good(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_next(b);
            tick(1'b1, b);
        end
    endtask

    task automatic send_bad();
        logic b;
        gen_next(b);
        tick(1'b1, ~b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        checks++;
        if ({locked, err_pulse, err_count, exp_state} !== 23'd0) begin
            failures++;
            $display("FAIL reset_hold got=%0h want=0", {locked, err_pulse, err_count, exp_state});
        end
        do_reset();
        tick(1'b0, 1'b0);
        checks++;
        if ({locked, err_pulse, err_count, exp_state} !== 23'd0) begin
            failures++;
            $display("FAIL reset_release got=%0h want=0", {locked, err_pulse, err_count, exp_state});
        end
    endtask

    task automatic test_clean_lock();
        logic b;
        logic [4:0] snap;
        do_reset();
        for (int i = 1; i <= 13; i++) begin
            gen_next(b);
            tick(1'b1, b);
            checks++;
            if (locked !== (i >= 13)) begin
                failures++;
                $display("FAIL lock_point bit=%0d got=%0b want=%0b", i, locked, (i >= 13));
            end
        end
        snap = exp_state;
        for (int i = 1; i <= 62; i++) begin
            gen_next(b);
            tick(1'b1, b);
            checks++;
            if (exp_state !== gen || err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL clean_state bit=%0d got=%0h/%0b want=%0h/0", i, exp_state, err_pulse, gen);
            end
            if (i == 31 || i == 62) begin
                checks++;
                if (exp_state !== snap) begin
                    failures++;
                    $display("FAIL period31 bit=%0d got=%0h want=%0h", i, exp_state, snap);
                end
            end
        end
        checks++;
        if (err_count !== 16'd0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL clean_errcount got=%0d/%0b want=0/1", err_count, locked);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        send_good(13);
        send_bad();
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL single_err got=%0b/%0d/%0b want=1/1/1", err_pulse, err_count, locked);
        end
        send_good(1);
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 16'd1) begin
            failures++;
            $display("FAIL single_err_after got=%0b/%0d want=0/1", err_pulse, err_count);
        end
        // three more errors must not drop lock if the miss run was reset
        repeat (3) send_bad();
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd4) begin
            failures++;
            $display("FAIL miss_reset got=%0b/%0d want=1/4", locked, err_count);
        end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        send_good(13);
        repeat (3) send_bad();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_early got=%0b want=1", locked);
        end
        send_bad();
        checks++;
        if (locked !== 1'b0 || err_count !== 16'd4) begin
            failures++;
            $display("FAIL loss_point got=%0b/%0d want=0/4", locked, err_count);
        end
        send_good(12);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL relock_early got=%0b want=0", locked);
        end
        send_good(1);
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd4) begin
            failures++;
            $display("FAIL relock got=%0b/%0d want=1/4", locked, err_count);
        end
    endtask

    task automatic test_all_zero();
        int seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b0);
            if (locked !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL all_zero locked_cycles=%0d errs=%0d want=0/0", seen, err_count);
        end
    endtask

    task automatic test_controls();
        logic b;
        // reinit mid-LOCKED together with a valid bit
        do_reset();
        send_good(13);
        send_bad();
        send_good(1);
        reinit = 1'b1;
        gen_next(b);
        tick(1'b1, b);
        reinit = 1'b0;
        checks++;
        if (locked !== 1'b0 || err_count !== 16'd1 || exp_state !== 5'd0) begin
            failures++;
            $display("FAIL reinit got=%0b/%0d/%0h want=0/1/0", locked, err_count, exp_state);
        end
        // clear colliding with an error at count 7
        do_reset();
        send_good(13);
        repeat (7) begin
            send_bad();
            send_good(1);
        end
        checks++;
        if (err_count !== 16'd7) begin
            failures++;
            $display("FAIL err_seven got=%0d want=7", err_count);
        end
        clr_err = 1'b1;
        send_bad();
        checks++;
        if (err_count !== 16'd1) begin
            failures++;
            $display("FAIL clr_collide got=%0d want=1", err_count);
        end
        send_good(1);
        clr_err = 1'b0;
        checks++;
        if (err_count !== 16'd0) begin
            failures++;
            $display("FAIL clr_plain got=%0d want=0", err_count);
        end
        // asynchronous reset in the middle of a cycle
        send_bad();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, err_pulse, err_count, exp_state} !== 23'd0) begin
            failures++;
            $display("FAIL async_reset got=%0h want=0", {locked, err_pulse, err_count, exp_state});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_gapped_valid();
        logic b;
        logic v;
        int nvalid;
        int budget;
        do_reset();
        nvalid = 0;
        budget = 0;
        while (nvalid < 20 && budget < 400) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) begin
                gen_next(b);
                nvalid++;
            end else begin
                b = $urandom_range(0, 1) == 1;
            end
            tick(v, b);
            budget++;
            checks++;
            if (locked !== (nvalid >= 13) || err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL gapped_lock valid=%0d got=%0b/%0b want=%0b/0", nvalid, locked, err_pulse, (nvalid >= 13));
            end
        end
        checks++;
        if (nvalid < 20) begin
            failures++;
            $display("FAIL gapped_budget got=%0d want=20", nvalid);
        end
        send_bad();
        tick(1'b0, 1'b0);
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 16'd1) begin
            failures++;
            $display("FAIL gapped_idle_pulse got=%0b/%0d want=0/1", err_pulse, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_all_zero();
        test_controls();
        test_gapped_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's LFSR pattern generator. Takes the serial bit stream produced by `lfsr` (one bit per `advance`), self-synchronises to it, and locks once enough consecutive bits match.
- While locked, it flags and counts bit errors.
- Sits at the far end of PRBS/BIST links. It uses the same `taps`/state convention as the generator, so one tap vector drives both ends.

Parameters:
- WIDTH, 5, LFSR length; must equal the generator's WIDTH.
- LOCK_COUNT, 8, consecutive matching bits in VERIFY required to lock (1..255).
- LOSS_COUNT, 4, consecutive mismatches in LOCKED that drop lock (1..255).
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- reinit  input  1  synchronous restart of synchronisation (to HUNT); dominant over in_valid.
- taps  input  WIDTH  feedback taps; static while running, any change requires reinit.
- in_valid  input  1  in_bit is sampled this cycle (mirrors generator `advance`).
- in_bit  input  1  received stream bit (generator `out`).
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle flag: the bit sampled last cycle mismatched while LOCKED.
- err_count  output  ERR_W  saturating count of mismatches while LOCKED.
- exp_state  output  WIDTH  current history/reference register (debug).

Behaviour:
- Stream model:
  - Generator state s, with s[k] = b(n-k).
  - Next bit b(n+1) = XOR over k of (taps[k] & b(n-k)).
  - Checker history h[WIDTH-1:0] uses the same mapping. On an accepted bit: h <= {h[WIDTH-2:0], bit}.
  - Prediction p = ^(taps & h), computed combinationally from the current h.
- Reset (rst_n low, async): state=HUNT; h=0; fill_cnt=0; match_cnt=0; miss_cnt=0; locked=0; err_pulse=0; err_count=0.
- HUNT:
  - Each in_valid shifts in_bit into h and increments fill_cnt.
  - When WIDTH bits have been accepted -> VERIFY, with match_cnt=0.
- VERIFY:
  - Each in_valid compares in_bit with p, then shifts in_bit into h (self-synchronising).
  - Match with h != 0: match_cnt+1.
  - Match with h == 0: match_cnt unchanged, because an all-zero stream must never lock.
  - Mismatch: match_cnt=0.
  - When match_cnt reaches LOCK_COUNT -> LOCKED. locked rises on the clock edge that samples the LOCK_COUNT-th match, so it is visible the following cycle.
- LOCKED:
  - Each in_valid shifts p, not in_bit, into h (free-running reference; errors do not propagate).
  - Mismatch: err_pulse=1 next cycle; err_count+1 (saturates at all-ones); miss_cnt+1.
  - Match: miss_cnt=0.
  - When miss_cnt reaches LOSS_COUNT -> HUNT. On that transition: locked=0, fill_cnt=0, h keeps its value. The LOSS_COUNT-th error is still counted.
- err_pulse is 0 in every cycle not described above, including when in_valid=0.
- Priority, highest first:
  - rst_n.
  - reinit: -> HUNT, clear fill_cnt/match_cnt/miss_cnt/locked/err_pulse/h; err_count kept.
  - Normal operation.
- clr_err:
  - Zeroes err_count on the same edge.
  - If an error is counted in the same cycle, the result is 1, not 0.
- No latency beyond one register stage on every output; all outputs are registered.
- taps=0: prediction is always 0, so only an all-zero stream matches, and that stream is excluded from locking. The checker never locks.

Optional Feature:
- Macro LFSR_CHECKER_INVERT_EN.
- Defined: adds input port `invert` (1 bit). The effective bit is in_bit ^ invert in every state, supporting inverted-polarity links. invert must be static while locked.
- Undefined: no `invert` port; in_bit is used directly.

Test Plan:
- Clean lock:
  - Stimulus: WIDTH=5, taps=5'b10100, generator seeded 5'b00001, in_valid every cycle.
  - Required: locked=1 in the cycle after the 13th valid bit (5 HUNT + 8 VERIFY); err_count stays 0 over 62 further bits; exp_state repeats with period 31.
- Single error:
  - Stimulus: while locked, flip one in_bit.
  - Required: err_pulse high for exactly one cycle; err_count=1; locked stays 1; the next bits match and miss_cnt returns to 0.
- Loss of lock:
  - Stimulus: while locked, drive 4 consecutive wrong bits.
  - Required: err_count=4; locked=0 the cycle after the 4th; after 13 correct bits locked=1 again.
- All-zero stream:
  - Stimulus: in_bit=0 for 100 valid cycles with taps=5'b10100.
  - Required: locked never asserts; err_count=0.
- Control edge cases:
  - Stimulus: assert reinit mid-LOCKED together with in_valid; separately, assert clr_err in the same cycle as an error at err_count=7; separately, pull rst_n low asynchronously mid-cycle.
  - Required: reinit gives locked=0 next cycle with err_count held; the clr_err collision gives err_count=1; rst_n low clears all outputs immediately.
- Gapped valid:
  - Stimulus: in_valid with a random 50% duty.
  - Required: same lock point measured in valid bits as the clean-lock case; no err_pulse while in_valid=0.
